// File: rtl/conv_bias_relu_stage_pkg.sv
// Shared constants and width helpers for the conv bias/ReLU output stage.
package conv_bias_relu_stage_pkg;

   localparam int unsigned FP32_SIGN_BIT  = 31;
   localparam logic [31:0] FP32_ZERO      = 32'h0000_0000;
   localparam int unsigned FP_ADD_LAT_DEF = 3;

   // Index width for a counter or address spanning n entries; never narrower than 1 bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_bias_relu_stage_if.sv
// Pixel stream, bias write port and tagged result bus of the bias/ReLU stage.
interface conv_bias_relu_stage_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CH_W       = 6
);
   logic                  bias_wr_en;
   logic [CH_W-1:0]       bias_wr_addr;
   logic [DATA_WIDTH-1:0] bias_wr_data;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  valid_out;
   logic [CH_W-1:0]       channel_out;
   logic                  last_pixel_out;
   logic                  frame_done;

   modport master (
      output bias_wr_en, bias_wr_addr, bias_wr_data, valid_in, pxl_in,
      input  pxl_out, valid_out, channel_out, last_pixel_out, frame_done
   );

   modport slave (
      input  bias_wr_en, bias_wr_addr, bias_wr_data, valid_in, pxl_in,
      output pxl_out, valid_out, channel_out, last_pixel_out, frame_done
   );
endinterface

// File: rtl/conv_bias_relu_stage_bias_rf.sv
// Per-output-channel FP32 bias register file: one write port, one combinational read port.
module conv_bias_regfile #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_W     = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en_i,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] bias_q [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) bias_q[i] <= '0;
      end else if (wr_en_i && 32'(wr_addr_i) < DEPTH) begin
         bias_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
   assign rd_data_o = (32'(rd_addr_i) < DEPTH) ? bias_q[rd_addr_i] : '0;

endmodule

// File: rtl/fp_add_sub.sv
// Pipelined IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
module fp_add_sub #(
   parameter int unsigned LAT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] result
);

   function automatic logic [31:0] fp32_add(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] x, y;
      logic        sx, eff_sub, ru;
      logic [9:0]  ex, ey, e, d;
      logic [23:0] mx, my;
      logic [26:0] ax, ay;
      logic [53:0] t;
      logic [27:0] s;
      logic [24:0] rm;
      if (a_in[30:23] == 8'hFF && a_in[22:0] != 23'd0) return a_in | 32'h0040_0000;
      if (b_in[30:23] == 8'hFF && b_in[22:0] != 23'd0) return b_in | 32'h0040_0000;
      if (a_in[30:23] == 8'hFF && b_in[30:23] == 8'hFF && a_in[31] != b_in[31]) return 32'h7FC0_0000;
      if (a_in[30:23] == 8'hFF) return a_in;
      if (b_in[30:23] == 8'hFF) return b_in;
      if (a_in[30:0] >= b_in[30:0]) begin
         x = a_in;
         y = b_in;
      end else begin
         x = b_in;
         y = a_in;
      end
      sx      = x[31];
      eff_sub = x[31] ^ y[31];
      // Subnormals use effective exponent 1 with no hidden bit.
      ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
      ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
      mx = {x[30:23] != 8'd0, x[22:0]};
      my = {y[30:23] != 8'd0, y[22:0]};
      d  = ex - ey;
      if (d > 10'd27) d = 10'd27;
      ax = {mx, 3'b000};
      t  = {my, 30'd0} >> d;
      ay = t[53:27];
      ay[0] = ay[0] | (|t[26:0]);
      e  = ex;
      s  = eff_sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
      if (s == 28'd0) return 32'h0000_0000;
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 10'd1;
      end
      for (int unsigned i = 0; i < 26; i++) begin
         if (!s[26] && e > 10'd1) begin
            s = s << 1;
            e = e - 10'd1;
         end
      end
      ru = s[2] & (s[3] | s[1] | s[0]);
      rm = {1'b0, s[26:3]} + 25'(ru);
      if (rm[24]) begin
         rm = rm >> 1;
         e  = e + 10'd1;
      end
      if (e >= 10'd255) return {sx, 8'hFF, 23'd0};
      return {sx, rm[23] ? e[7:0] : 8'h00, rm[22:0]};
   endfunction

   logic [31:0] sum_d;
   logic [31:0] pipe_q [LAT];

   assign sum_d = fp32_add(a, b ^ {sub, 31'd0});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= sum_d;
         for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign result = pipe_q[LAT-1];

endmodule

// File: rtl/conv_bias_relu_stage.sv
// Adds per-channel bias to the channel-serial FP32 conv stream, applies optional ReLU, tags channel/frame.
module conv_bias_relu_stage
   import conv_bias_relu_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned IMAGE_SIZE      = 612,
   parameter int unsigned CHANNEL_NUM_OUT = 64,
   parameter int unsigned FP_ADD_LAT      = FP_ADD_LAT_DEF,
   parameter int unsigned RELU_EN         = 1,
   parameter int unsigned CH_W            = idx_w(CHANNEL_NUM_OUT),
   parameter int unsigned PX_W            = idx_w(IMAGE_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset,
   conv_bias_relu_stage_if.slave  bus
);

   logic [PX_W-1:0]       pix_cnt_q, pix_cnt_d;
   logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
   logic                  last_pix, last_ch;
   logic [DATA_WIDTH-1:0] bias_rd;

   logic [DATA_WIDTH-1:0] s0_pxl_q, s0_bias_q;
   logic [CH_W-1:0]       s0_ch_q;
   logic                  s0_last_q, s0_frame_q, s0_valid_q;

   logic [CH_W-1:0]       tag_ch_q    [FP_ADD_LAT];
   logic                  tag_last_q  [FP_ADD_LAT];
   logic                  tag_frame_q [FP_ADD_LAT];
   logic                  tag_valid_q [FP_ADD_LAT];

   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
   logic [CH_W-1:0]       ch_out_q;
   logic                  valid_out_q, last_out_q, frame_out_q;

   assign last_pix = (pix_cnt_q == PX_W'(IMAGE_SIZE - 1));
   assign last_ch  = (ch_cnt_q == CH_W'(CHANNEL_NUM_OUT - 1));

   always_comb begin
      pix_cnt_d = pix_cnt_q;
      ch_cnt_d  = ch_cnt_q;
      if (bus.valid_in) begin
         pix_cnt_d = last_pix ? '0 : pix_cnt_q + PX_W'(1);
         if (last_pix) ch_cnt_d = last_ch ? '0 : ch_cnt_q + CH_W'(1);
      end
   end

   conv_bias_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (CHANNEL_NUM_OUT),
      .ADDR_W     (CH_W)
   ) u_bias_rf (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (bus.bias_wr_en),
      .wr_addr_i (bus.bias_wr_addr),
      .wr_data_i (bus.bias_wr_data),
      .rd_addr_i (ch_cnt_q),
      .rd_data_o (bias_rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt_q  <= '0;
         ch_cnt_q   <= '0;
         s0_pxl_q   <= '0;
         s0_bias_q  <= '0;
         s0_ch_q    <= '0;
         s0_last_q  <= 1'b0;
         s0_frame_q <= 1'b0;
         s0_valid_q <= 1'b0;
      end else begin
         pix_cnt_q  <= pix_cnt_d;
         ch_cnt_q   <= ch_cnt_d;
         s0_valid_q <= bus.valid_in;
         if (bus.valid_in) begin
            s0_pxl_q   <= bus.pxl_in;
            s0_bias_q  <= bias_rd;
            s0_ch_q    <= ch_cnt_q;
            s0_last_q  <= last_pix;
            s0_frame_q <= last_pix && last_ch;
         end
      end
   end

   fp_add_sub #(
      .LAT (FP_ADD_LAT)
   ) u_fp_add (
      .clk    (clk),
      .reset  (~reset),
      .a      (s0_pxl_q),
      .b      (s0_bias_q),
      .sub    (1'b0),
      .result (sum)
   );

   // Tag travels alongside the adder so it emerges with the matching sum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < FP_ADD_LAT; i++) begin
            tag_ch_q[i]    <= '0;
            tag_last_q[i]  <= 1'b0;
            tag_frame_q[i] <= 1'b0;
            tag_valid_q[i] <= 1'b0;
         end
      end else begin
         tag_ch_q[0]    <= s0_ch_q;
         tag_last_q[0]  <= s0_last_q & s0_valid_q;
         tag_frame_q[0] <= s0_frame_q & s0_valid_q;
         tag_valid_q[0] <= s0_valid_q;
         for (int unsigned i = 1; i < FP_ADD_LAT; i++) begin
            tag_ch_q[i]    <= tag_ch_q[i-1];
            tag_last_q[i]  <= tag_last_q[i-1];
            tag_frame_q[i] <= tag_frame_q[i-1];
            tag_valid_q[i] <= tag_valid_q[i-1];
         end
      end
   end

   // Any set sign bit clamps, so -0 and negative NaN also become +0.
   assign pxl_out_d = (RELU_EN != 0 && sum[FP32_SIGN_BIT]) ? FP32_ZERO : sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pxl_out_q   <= '0;
         ch_out_q    <= '0;
         valid_out_q <= 1'b0;
         last_out_q  <= 1'b0;
         frame_out_q <= 1'b0;
      end else begin
         valid_out_q <= tag_valid_q[FP_ADD_LAT-1];
         last_out_q  <= tag_valid_q[FP_ADD_LAT-1] & tag_last_q[FP_ADD_LAT-1];
         frame_out_q <= tag_valid_q[FP_ADD_LAT-1] & tag_frame_q[FP_ADD_LAT-1];
         if (tag_valid_q[FP_ADD_LAT-1]) begin
            pxl_out_q <= pxl_out_d;
            ch_out_q  <= tag_ch_q[FP_ADD_LAT-1];
         end
      end
   end

   assign bus.pxl_out        = pxl_out_q;
   assign bus.valid_out      = valid_out_q;
   assign bus.channel_out    = ch_out_q;
   assign bus.last_pixel_out = last_out_q;
   assign bus.frame_done     = frame_out_q;

endmodule

// File: tb/tb_conv_bias_relu_stage.sv
// Scoreboard bench: ReLU-on and ReLU-off instances share stimulus; monitors check each output stream.
module tb_conv_bias_relu_stage;

   localparam int unsigned LAT = 3;

   typedef struct {
      logic [31:0] data;
      logic        ch;
      logic        lp;
      logic        fd;
      int          cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_pass;
   exp_t q_r[$];
   exp_t q_b[$];

   conv_bias_relu_stage_if #(.DATA_WIDTH(32), .CH_W(1)) bus_r ();
   conv_bias_relu_stage_if #(.DATA_WIDTH(32), .CH_W(1)) bus_b ();

   conv_bias_relu_stage #(
      .DATA_WIDTH(32), .IMAGE_SIZE(4), .CHANNEL_NUM_OUT(2), .FP_ADD_LAT(LAT), .RELU_EN(1)
   ) dut_r (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_r.slave)
   );

   conv_bias_relu_stage #(
      .DATA_WIDTH(32), .IMAGE_SIZE(4), .CHANNEL_NUM_OUT(2), .FP_ADD_LAT(LAT), .RELU_EN(0)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic mon(input int which, input logic v, input logic [31:0] d, input logic ch,
                      input logic lp, input logic fd);
      exp_t  e;
      string tag;
      tag = (which == 0) ? "relu" : "bypass";
      if (v) begin
         if ((which == 0 && q_r.size() == 0) || (which == 1 && q_b.size() == 0)) begin
            check({tag, " unexpected_valid"}, 32'(v), 32'd0);
         end else begin
            e = (which == 0) ? q_r.pop_front() : q_b.pop_front();
            check({tag, " latency"}, 32'(cyc), 32'(e.cyc));
            check({tag, " pxl_out"}, d, e.data);
            check({tag, " channel_out"}, 32'(ch), 32'(e.ch));
            check({tag, " last_pixel_out"}, 32'(lp), 32'(e.lp));
            check({tag, " frame_done"}, 32'(fd), 32'(e.fd));
         end
      end else if (lp || fd) begin
         check({tag, " idle_pulse"}, {30'd0, lp, fd}, 32'd0);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            mon(0, bus_r.valid_out, bus_r.pxl_out, bus_r.channel_out, bus_r.last_pixel_out, bus_r.frame_done);
            mon(1, bus_b.valid_out, bus_b.pxl_out, bus_b.channel_out, bus_b.last_pixel_out, bus_b.frame_done);
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] px, input logic [31:0] sum,
                        input logic ch, input logic lp, input logic fd,
                        input logic we = 1'b0, input logic wa = 1'b0, input logic [31:0] wd = '0);
      exp_t e;
      @(negedge clk);
      bus_r.valid_in = v;      bus_b.valid_in = v;
      bus_r.pxl_in = px;       bus_b.pxl_in = px;
      bus_r.bias_wr_en = we;   bus_b.bias_wr_en = we;
      bus_r.bias_wr_addr = wa; bus_b.bias_wr_addr = wa;
      bus_r.bias_wr_data = wd; bus_b.bias_wr_data = wd;
      if (v) begin
         e.ch = ch; e.lp = lp; e.fd = fd; e.cyc = cyc + int'(LAT) + 2;
         e.data = sum;
         q_b.push_back(e);
         e.data = sum[31] ? 32'h0000_0000 : sum;
         q_r.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic outputs_zero(input string name);
      check({name, " relu valid_out"}, 32'(bus_r.valid_out), 32'd0);
      check({name, " relu pxl_out"}, bus_r.pxl_out, 32'd0);
      check({name, " relu channel_out"}, 32'(bus_r.channel_out), 32'd0);
      check({name, " relu last/frame"}, {30'd0, bus_r.last_pixel_out, bus_r.frame_done}, 32'd0);
      check({name, " bypass valid_out"}, 32'(bus_b.valid_out), 32'd0);
      check({name, " bypass pxl_out"}, bus_b.pxl_out, 32'd0);
      check({name, " bypass channel_out"}, 32'(bus_b.channel_out), 32'd0);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && (q_r.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
      check({name, " pending_outputs"}, 32'(q_r.size() + q_b.size()), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset = 1'b0;
      bus_r.valid_in = 1'b0; bus_b.valid_in = 1'b0;
      bus_r.pxl_in = '0;     bus_b.pxl_in = '0;
      bus_r.bias_wr_en = 1'b0;   bus_b.bias_wr_en = 1'b0;
      bus_r.bias_wr_addr = 1'b0; bus_b.bias_wr_addr = 1'b0;
      bus_r.bias_wr_data = '0;   bus_b.bias_wr_data = '0;
      #3;
      outputs_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // bias[0]=1.0, bias[1]=0.5
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3F80_0000);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3F00_0000);

      // nine contiguous pixels across a frame boundary
      drive(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'hC0A0_0000, 32'hC080_0000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h0000_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 32'h3F80_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'hBF80_0000, 32'hBF00_0000, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h4000_0000, 32'h4020_0000, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h3F00_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 32'h4080_0000, 32'h40A0_0000, 1'b0, 1'b0, 1'b0);

      // gapped pattern 1,0,0,1,1,0,1
      drive(1'b1, 32'h4040_0000, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
      idle(2);
      drive(1'b1, 32'h0000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b1, 1'b0);
      idle(1);
      drive(1'b1, 32'h3F80_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0);

      // finish channel 1 so the frame wraps
      drive(1'b1, 32'h3F00_0000, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h3FC0_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h0000_0000, 32'h3F00_0000, 1'b1, 1'b1, 1'b1);

      // bias[0] <- 2.0 alongside a ch-0 pixel: that pixel still sees 1.0
      drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0000);
      drive(1'b1, 32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h0000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h0000_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 32'h3F80_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0);
      idle(1);
      drain("stream");

      // async reset mid-channel 1 with a pixel in flight; it must never emerge
      drive(1'b1, 32'h3F80_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0);
      idle(1);
      #2;
      reset = 1'b0;
      q_r.delete();
      q_b.delete();
      #1;
      outputs_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
      idle(LAT + 4);
      drain("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
